// File: rtl/cpu_bus_frontend.sv
// cpu_bus_frontend: 6502/Z80 host bus front end with strobe sync, settle FSM, read path and write FIFO.
// Define HALT_EN to enable the registered halt_req/halt_ack host stall.
module cpu_bus_frontend #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 8,
    parameter int                BUS_MODE    = 0,
    parameter int                SYNC_STAGES = 2,
    parameter int                SETTLE_CYC  = 3,
    parameter logic [ADDR_W-1:0] MAP_BASE    = 'hC000,
    parameter logic [ADDR_W-1:0] MAP_MASK    = 'hC000,
    parameter int                WFIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic              phi2,
    input  logic              rwbar,
    input  logic              mreq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_req,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              dataoutenable,
    output logic              busenable,
    input  logic              rdyin,
    output logic              rdy,
    output logic              wf_valid,
    input  logic              wf_ready,
    output logic [ADDR_W-1:0] wf_addr,
    output logic [DATA_W-1:0] wf_data,
    output logic              wf_overflow,
    input  logic              halt_req,
    output logic              halt_ack
);
    localparam int PW = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam int CW = $clog2(WFIFO_DEPTH) + 1;
    localparam int FW = ADDR_W + DATA_W;

    typedef enum logic [2:0] {IDLE, SETTLE, REQ, WAIT, DRIVE, HOLD} state_t;

    // Sync chain carries {phi2, mreq_n, rd_n, wr_n}; reset to the idle bus levels.
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] sync_d [SYNC_STAGES];
    logic [3:0] s;
    logic       strobe, strobe_prev_q, cyc_start, cyc_end, is_read, hit;
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              req_q, req_d, doe_q, doe_d, be_q, be_d, ovf_q, ovf_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]     fcnt_q, fcnt_d;
    logic              push, pop, full, push_ok;
    logic [FW-1:0]     fifo_q [WFIFO_DEPTH];
    logic              unused_inputs;

    assign s         = sync_q[SYNC_STAGES-1];
    assign strobe    = (BUS_MODE == 1) ? (!s[2] && (!s[1] || !s[0])) : s[3];
    assign cyc_start = strobe && !strobe_prev_q;
    assign cyc_end   = !strobe && strobe_prev_q;
    assign is_read   = (BUS_MODE == 1) ? !s[1] : rwbar;
    assign hit       = (address & MAP_MASK) == MAP_BASE;

    assign wf_valid  = fcnt_q != '0;
    assign full      = fcnt_q == CW'(WFIFO_DEPTH);
    assign pop       = wf_valid && wf_ready;
    assign push_ok   = push && (!full || pop);

    always_comb begin
        sync_d[0] = {phi2, mreq_n, rd_n, wr_n};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        req_d      = 1'b0;
        doe_d      = doe_q;
        be_d       = be_q;
        dout_d     = dout_q;
        push       = 1'b0;
        if (state_q != IDLE && cyc_end) begin
            state_d = IDLE;
            doe_d   = 1'b0;
            be_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cyc_start) begin
                        state_d = SETTLE;
                        cnt_d   = 4'd1;
                    end
                end
                SETTLE: begin
                    if (cnt_q == 4'(SETTLE_CYC)) begin
                        mem_addr_d = address;
                        state_d    = (hit && is_read) ? REQ : HOLD;
                        req_d      = hit && is_read;
                        be_d       = hit;
                        push       = hit && !is_read;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                REQ, WAIT: begin
                    state_d = mem_rd_valid ? DRIVE : WAIT;
                    doe_d   = mem_rd_valid;
                    dout_d  = mem_rd_valid ? mem_rd_data : dout_q;
                end
                default: ;
            endcase
        end
        wp_d   = wp_q + PW'(push_ok);
        rp_d   = rp_q + PW'(pop);
        fcnt_d = fcnt_q + CW'(push_ok) - CW'(pop);
        ovf_d  = ovf_q || (push && full && !pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= '{default: 4'b0111};
            strobe_prev_q <= 1'b0;
            state_q       <= IDLE;
            cnt_q         <= '0;
            mem_addr_q    <= '0;
            req_q         <= 1'b0;
            doe_q         <= 1'b0;
            be_q          <= 1'b0;
            dout_q        <= '0;
            wp_q          <= '0;
            rp_q          <= '0;
            fcnt_q        <= '0;
            ovf_q         <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            strobe_prev_q <= strobe;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_addr_q    <= mem_addr_d;
            req_q         <= req_d;
            doe_q         <= doe_d;
            be_q          <= be_d;
            dout_q        <= dout_d;
            wp_q          <= wp_d;
            rp_q          <= rp_d;
            fcnt_q        <= fcnt_d;
            ovf_q         <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wp_q] <= {address, data_in};
    end

    assign data_out      = dout_q;
    assign mem_addr      = mem_addr_q;
    assign mem_rd_req    = req_q;
    assign dataoutenable = doe_q;
    assign busenable     = be_q;
    assign wf_overflow   = ovf_q;
    assign wf_addr       = fifo_q[rp_q][FW-1:DATA_W];
    assign wf_data       = fifo_q[rp_q][DATA_W-1:0];

`ifdef HALT_EN
    // Halt is only taken between bus cycles but held until the host drops the request.
    logic halt_q, halt_d;
    always_comb halt_d = halt_q ? halt_req : (halt_req && state_q == IDLE);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) halt_q <= 1'b0;
        else        halt_q <= halt_d;
    end
    assign rdy      = halt_q ? 1'b0 : rdyin;
    assign halt_ack = halt_q;
`else
    assign rdy      = rdyin;
    assign halt_ack = 1'b0;
`endif

    assign unused_inputs = ^{halt_req, rwbar};
endmodule

// File: tb/tb_cpu_bus_frontend.sv
// tb_cpu_bus_frontend: directed bench; instance a runs 6502 mode, instance b runs Z80 mode.
module tb_cpu_bus_frontend;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] address = '0;
    logic [7:0]  data_in = '0;
    logic        phi2 = 1'b0, rwbar = 1'b1, mreq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic        mem_rd_valid = 1'b0;
    logic [7:0]  mem_rd_data = '0;
    logic        rdyin = 1'b1, wf_ready = 1'b0, halt_req = 1'b0;
    logic [7:0]  a_dout, b_dout, a_wf_data, b_wf_data;
    logic [15:0] a_mem_addr, b_mem_addr, a_wf_addr, b_wf_addr;
    logic        a_req, a_doe, a_be, a_rdy, a_wf_valid, a_ovf, a_halt_ack;
    logic        b_req, b_doe, b_be, b_rdy, b_wf_valid, b_ovf, b_halt_ack;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    cpu_bus_frontend #(.BUS_MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in), .data_out(a_dout),
        .phi2(phi2), .rwbar(rwbar), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n),
        .mem_addr(a_mem_addr), .mem_rd_req(a_req), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .dataoutenable(a_doe), .busenable(a_be), .rdyin(rdyin), .rdy(a_rdy),
        .wf_valid(a_wf_valid), .wf_ready(wf_ready), .wf_addr(a_wf_addr), .wf_data(a_wf_data),
        .wf_overflow(a_ovf), .halt_req(halt_req), .halt_ack(a_halt_ack));

    cpu_bus_frontend #(.BUS_MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in), .data_out(b_dout),
        .phi2(phi2), .rwbar(rwbar), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n),
        .mem_addr(b_mem_addr), .mem_rd_req(b_req), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .dataoutenable(b_doe), .busenable(b_be), .rdyin(rdyin), .rdy(b_rdy),
        .wf_valid(b_wf_valid), .wf_ready(wf_ready), .wf_addr(b_wf_addr), .wf_data(b_wf_data),
        .wf_overflow(b_ovf), .halt_req(halt_req), .halt_ack(b_halt_ack));

    task automatic z80_write(input logic [15:0] a, input logic [7:0] d);
        address = a;
        data_in = d;
        mreq_n  = 1'b0;
        wr_n    = 1'b0;
        repeat (8) @(negedge clk);
        mreq_n  = 1'b1;
        wr_n    = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic m0_read_to_drive(input logic [15:0] a, input logic [7:0] d, output bit found);
        int n = 0;
        address = a;
        rwbar   = 1'b1;
        phi2    = 1'b1;
        while (a_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        found = (a_req === 1'b1);
        @(negedge clk);
        @(negedge clk);
        mem_rd_valid = 1'b1;
        mem_rd_data  = d;
        @(negedge clk);
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
    endtask

    task automatic test_reset();
        rdyin = 1'b0;
        #12;
        total++;
        if ({a_req, a_doe, a_be, a_wf_valid, a_ovf, a_halt_ack} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000000", {a_req, a_doe, a_be, a_wf_valid, a_ovf, a_halt_ack});
        end
        total++;
        if (a_dout !== 8'h00 || a_mem_addr !== 16'h0000) begin
            bad++;
            $display("FAIL reset_data: got dout=%h addr=%h want 00 0000", a_dout, a_mem_addr);
        end
        total++;
        if (a_rdy !== 1'b0 || b_wf_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_rdy0: got rdy=%b bvalid=%b want 0 0", a_rdy, b_wf_valid);
        end
        rdyin = 1'b1;
        #1;
        total++;
        if (a_rdy !== 1'b1) begin
            bad++;
            $display("FAIL reset_rdy1: got %b want 1", a_rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read_hit();
        int n = 0;
        int reqs = 0;
        address = 16'hC123;
        rwbar   = 1'b1;
        phi2    = 1'b1;
        while (a_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (a_req !== 1'b1) begin
            bad++;
            $display("FAIL hit_req: got %b want 1 within 20 clk", a_req);
        end
        total++;
        if (a_mem_addr !== 16'hC123) begin
            bad++;
            $display("FAIL hit_addr: got %h want c123", a_mem_addr);
        end
        total++;
        if (a_be !== 1'b1 || a_doe !== 1'b0) begin
            bad++;
            $display("FAIL hit_req_bus: got be=%b doe=%b want 1 0", a_be, a_doe);
        end
        @(negedge clk);
        total++;
        if (a_req !== 1'b0) begin
            bad++;
            $display("FAIL hit_req_pulse: got %b want 0", a_req);
        end
        @(negedge clk);
        mem_rd_valid = 1'b1;
        mem_rd_data  = 8'hA5;
        @(negedge clk);
        mem_rd_valid = 1'b0;
        mem_rd_data  = 8'h00;
        total++;
        if (a_doe !== 1'b1 || a_be !== 1'b1 || a_dout !== 8'hA5) begin
            bad++;
            $display("FAIL hit_drive: got doe=%b be=%b dout=%h want 1 1 a5", a_doe, a_be, a_dout);
        end
        repeat (4) begin
            @(negedge clk);
            reqs += int'(a_req);
        end
        phi2 = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (a_doe !== 1'b1 || a_dout !== 8'hA5) begin
            bad++;
            $display("FAIL hit_drive_hold: got doe=%b dout=%h want 1 a5", a_doe, a_dout);
        end
        @(negedge clk);
        total++;
        if (a_doe !== 1'b0 || a_be !== 1'b0) begin
            bad++;
            $display("FAIL hit_end: got doe=%b be=%b want 0 0", a_doe, a_be);
        end
        total++;
        if (reqs !== 0) begin
            bad++;
            $display("FAIL hit_extra_req: got %0d want 0", reqs);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_read_miss();
        int viol = 0;
        address = 16'h1234;
        rwbar   = 1'b1;
        phi2    = 1'b1;
        repeat (12) begin
            @(negedge clk);
            viol += int'(a_req | a_doe | a_be);
        end
        phi2 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            viol += int'(a_req | a_doe | a_be);
        end
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL miss_quiet: got %0d active cycles want 0", viol);
        end
    endtask

    task automatic test_write_hold();
        address = 16'hC055;
        data_in = 8'h3C;
        rwbar   = 1'b0;
        phi2    = 1'b1;
        repeat (8) @(negedge clk);
        total++;
        if (a_be !== 1'b1 || a_doe !== 1'b0 || a_req !== 1'b0) begin
            bad++;
            $display("FAIL wr_hold: got be=%b doe=%b req=%b want 1 0 0", a_be, a_doe, a_req);
        end
        total++;
        if (a_wf_valid !== 1'b1 || a_wf_addr !== 16'hC055 || a_wf_data !== 8'h3C) begin
            bad++;
            $display("FAIL wr_push: got v=%b %h/%h want 1 c055/3c", a_wf_valid, a_wf_addr, a_wf_data);
        end
        phi2 = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (a_be !== 1'b0) begin
            bad++;
            $display("FAIL wr_end: got be=%b want 0", a_be);
        end
        wf_ready = 1'b1;
        @(negedge clk);
        wf_ready = 1'b0;
        rwbar    = 1'b1;
        total++;
        if (a_wf_valid !== 1'b0) begin
            bad++;
            $display("FAIL wr_pop: got valid=%b want 0", a_wf_valid);
        end
    endtask

    task automatic test_short_pulse();
        int viol = 0;
        address = 16'hC010;
        data_in = 8'h77;
        rwbar   = 1'b0;
        phi2    = 1'b1;
        repeat (2) @(negedge clk);
        phi2 = 1'b0;
        repeat (12) begin
            @(negedge clk);
            viol += int'(a_req | a_be | a_wf_valid);
        end
        rwbar = 1'b1;
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL short_abort: got %0d active cycles want 0", viol);
        end
    endtask

    task automatic test_write_fifo();
        for (int i = 0; i < 9; i++) z80_write(16'hC000 + 16'(i), 8'h10 + 8'(i));
        total++;
        if (b_wf_overflow_chk() !== 1'b1) begin
            bad++;
            $display("FAIL fifo_overflow: got %b want 1", b_ovf);
        end
        wf_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (b_wf_valid !== 1'b1 || b_wf_addr !== 16'hC000 + 16'(i) || b_wf_data !== 8'h10 + 8'(i)) begin
                bad++;
                $display("FAIL fifo_entry%0d: got v=%b %h/%h want 1 %h/%h", i, b_wf_valid, b_wf_addr,
                         b_wf_data, 16'hC000 + 16'(i), 8'h10 + 8'(i));
            end
            @(negedge clk);
        end
        wf_ready = 1'b0;
        total++;
        if (b_wf_valid !== 1'b0 || b_ovf !== 1'b1) begin
            bad++;
            $display("FAIL fifo_drained: got valid=%b ovf=%b want 0 1", b_wf_valid, b_ovf);
        end
    endtask

    function automatic logic b_wf_overflow_chk();
        return b_ovf;
    endfunction

    task automatic test_async_reset();
        bit found;
        z80_write(16'hC0AA, 8'h5A);
        m0_read_to_drive(16'hC200, 8'h99, found);
        total++;
        if (!found || a_doe !== 1'b1 || b_wf_valid !== 1'b1) begin
            bad++;
            $display("FAIL arst_pre: got found=%b doe=%b bvalid=%b want 1 1 1", found, a_doe, b_wf_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (a_doe !== 1'b0 || b_wf_valid !== 1'b0 || b_ovf !== 1'b0) begin
            bad++;
            $display("FAIL arst_now: got doe=%b bvalid=%b ovf=%b want 0 0 0", a_doe, b_wf_valid, b_ovf);
        end
        phi2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (b_wf_valid !== 1'b0 || b_ovf !== 1'b0 || a_doe !== 1'b0) begin
            bad++;
            $display("FAIL arst_after: got bvalid=%b ovf=%b doe=%b want 0 0 0", b_wf_valid, b_ovf, a_doe);
        end
    endtask

    task automatic test_halt();
`ifdef HALT_EN
        bit found;
        rdyin = 1'b1;
        m0_read_to_drive(16'hC300, 8'h42, found);
        halt_req = 1'b1;
        @(negedge clk);
        total++;
        if (!found || a_rdy !== 1'b1 || a_halt_ack !== 1'b0) begin
            bad++;
            $display("FAIL halt_midcycle: got found=%b rdy=%b ack=%b want 1 1 0", found, a_rdy, a_halt_ack);
        end
        phi2 = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (a_rdy !== 1'b1 || a_halt_ack !== 1'b0) begin
            bad++;
            $display("FAIL halt_wait_idle: got rdy=%b ack=%b want 1 0", a_rdy, a_halt_ack);
        end
        @(negedge clk);
        total++;
        if (a_rdy !== 1'b0 || a_halt_ack !== 1'b1) begin
            bad++;
            $display("FAIL halt_taken: got rdy=%b ack=%b want 0 1", a_rdy, a_halt_ack);
        end
        halt_req = 1'b0;
        @(negedge clk);
        total++;
        if (a_rdy !== 1'b1 || a_halt_ack !== 1'b0) begin
            bad++;
            $display("FAIL halt_release: got rdy=%b ack=%b want 1 0", a_rdy, a_halt_ack);
        end
`else
        halt_req = 1'b1;
        rdyin    = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (a_rdy !== 1'b0 || a_halt_ack !== 1'b0) begin
            bad++;
            $display("FAIL nohalt_low: got rdy=%b ack=%b want 0 0", a_rdy, a_halt_ack);
        end
        rdyin = 1'b1;
        #1;
        total++;
        if (a_rdy !== 1'b1 || a_halt_ack !== 1'b0) begin
            bad++;
            $display("FAIL nohalt_high: got rdy=%b ack=%b want 1 0", a_rdy, a_halt_ack);
        end
        halt_req = 1'b0;
`endif
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_read_miss();
        test_write_hold();
        test_short_pulse();
        test_write_fifo();
        test_async_reset();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
